instr_controller: RTL and testbench
===================================

Name: instr_controller

Overview:
- Instruction-decode and sequencing stage that sits directly upstream of the 16-bit datapath (register file, shifter, ALU, A/B/C/status registers).
- Latches a 16-bit instruction and decodes it.
- Runs a Moore FSM that drives every datapath control input (readnum, writenum, loada/b/c/s, asel, bsel, shift, ALUop, vsel, write, datapath_in).
- Executes one instruction per start pulse and reports idle on w.

Parameters:
- DW, 16, datapath and instruction width; only 16 is supported.
- RW, 3, register index width (8 registers).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  16  instruction word.
- load  input  1  latch `in` into the instruction register (IR); honoured only in WAIT.
- s  input  1  start execution; sampled only in WAIT.
- w  output  1  high exactly when the FSM is in WAIT.
- readnum  output  3  register file read index.
- writenum  output  3  register file write index.
- write  output  1  register file write enable.
- vsel  output  1  1 selects datapath_in; 0 selects C as the write-back value.
- loada  output  1  A register load.
- loadb  output  1  B register load.
- loadc  output  1  C register load.
- loads  output  1  status register load.
- asel  output  1  1 forces the ALU A input to 0.
- bsel  output  1  B source select; driven 0 always.
- shift  output  2  shifter op: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT B.
- datapath_in  output  16  sign-extended IR[7:0].

Behaviour:
- Encoding, IR fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0], imm8 = IR[7:0].
  - Legal instructions:
    - 110/10 MOV Rn,#imm8
    - 110/00 MOV Rd,Rm{,sh}
    - 101/00 ADD Rd,Rn,Rm{,sh}
    - 101/01 CMP Rn,Rm{,sh}
    - 101/10 AND Rd,Rn,Rm{,sh}
    - 101/11 MVN Rd,Rm{,sh}
  - Every other opcode/op combination is illegal.
- IR update: IR <= in on a clock edge where load=1 and state=WAIT. IR holds in all other cases.
- datapath_in = {{8{IR[7]}}, IR[7:0]} combinationally, in every state.
- States: WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM.
- Transitions:
  - WAIT -> DECODE when s=1; otherwise stays in WAIT.
  - From DECODE:
    - MOV imm -> WRITE_IMM.
    - MOV reg and MVN -> GET_B.
    - ADD, AND and CMP -> GET_A.
    - Illegal -> WAIT.
  - GET_A -> GET_B.
  - GET_B -> ALU.
  - ALU -> WAIT for CMP; otherwise ALU -> WRITE_REG.
  - WRITE_REG -> WAIT.
  - WRITE_IMM -> WAIT.
- Moore outputs: every output is 0 unless listed below for the current state.
  - WAIT: w=1.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU:
    - shift=sh.
    - ALUop = op (MOV reg uses 00).
    - asel=1 for MOV reg and MVN.
    - loads=1 for CMP; loadc=1 for all others.
  - WRITE_REG: writenum=Rd, write=1, vsel=0.
  - WRITE_IMM: writenum=Rn, write=1, vsel=1.
- Latency, counted from the s edge to w returning high:
  - MOV imm: 2 cycles.
  - Illegal: 1 cycle.
  - MOV reg and MVN: 4 cycles.
  - CMP: 4 cycles.
  - ADD and AND: 5 cycles.
- Boundary conditions:
  - load and s both high in WAIT: the IR captures `in` and the FSM enters DECODE on the same edge, so DECODE uses the new instruction.
  - load or s outside WAIT: ignored, no effect.
  - reset (any state, including mid-instruction): next state is WAIT and IR = 0; all outputs take WAIT values (w=1, everything else 0).
  - Abort guarantee: a reset asserted before WRITE_* is reached produces no register write.
  - reset has priority over load and s.

Decomposition:
- cpu_pkg:
  - state encoding enum.
  - opcode constants (OPC_MOV=3'b110, OPC_ALU=3'b101).
  - ALUop constants and shift constants.
  - IR field slice localparams.
- Sub-module instr_decoder: purely combinational. Maps IR to Rn, Rd, Rm, sh, op, the sign-extended imm, and one-hot instruction-class flags (is_movi, is_movr, is_alu2, is_cmp, is_mvn, illegal).
- instr_controller instantiates instr_decoder and contains the IR and the FSM.

Test Plan:
- Reset, then idle: reset=1 for 1 cycle -> w=1, write=loada=loadb=loadc=loads=0, datapath_in=16'h0000.
- MOV imm:
  - Stimulus: load in=16'hD1FE, pulse s.
  - Cycle 2: WRITE_IMM with writenum=1, write=1, vsel=1, datapath_in=16'hFFFE.
  - Cycle after: w=1.
- ADD:
  - Stimulus: load 16'hA148 (ADD R2,R1,R0,LSL#1), pulse s.
  - Required sequence: GET_A (readnum=1, loada=1); GET_B (readnum=0, loadb=1); ALU (shift=01, ALUop=00, asel=0, loadc=1); WRITE_REG (writenum=2, write=1, vsel=0).
  - w high again 5 cycles after s.
- CMP and MVN:
  - Load 16'hA801 (CMP R0,R1) -> ALU state has loads=1 and loadc=0; no write cycle follows; w high after 4 cycles.
  - Load 16'hB881 (MVN R4,R1) -> ALU has asel=1, ALUop=11; WRITE_REG has writenum=4.
- Illegal and ignored inputs:
  - Load 16'hE000, pulse s -> DECODE then WAIT; write never asserted.
  - Asserting load with in=16'hD007 during GET_B of an ADD -> IR unchanged; that ADD completes normally.
- Reset mid-op: start ADD 16'hA148, assert reset in the ALU state -> next cycle w=1, write stays 0 throughout, IR=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, opcode and
// ALU/shift encodings, IR field positions and the control-word layout.
package cpu_pkg;

   localparam int unsigned DW_C = 16;
   localparam int unsigned RW_C = 3;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_GET_A     = 3'd2,
      S_GET_B     = 3'd3,
      S_ALU       = 3'd4,
      S_WRITE_REG = 3'd5,
      S_WRITE_IMM = 3'd6
   } state_e;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOTB = 2'b11;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL1 = 2'b01;
   localparam logic [1:0] SH_LSR1 = 2'b10;
   localparam logic [1:0] SH_ASR1 = 2'b11;

   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 13;
   localparam int unsigned OP_MSB  = 12;
   localparam int unsigned OP_LSB  = 11;
   localparam int unsigned RN_MSB  = 10;
   localparam int unsigned RN_LSB  = 8;
   localparam int unsigned RD_MSB  = 7;
   localparam int unsigned RD_LSB  = 5;
   localparam int unsigned SH_MSB  = 4;
   localparam int unsigned SH_LSB  = 3;
   localparam int unsigned RM_MSB  = 2;
   localparam int unsigned RM_LSB  = 0;
   localparam int unsigned IMM_MSB = 7;

   // One registered control word per FSM state.
   typedef struct packed {
      logic            w;
      logic [RW_C-1:0] readnum;
      logic [RW_C-1:0] writenum;
      logic            write;
      logic            vsel;
      logic            loada;
      logic            loadb;
      logic            loadc;
      logic            loads;
      logic            asel;
      logic [1:0]      shift;
      logic [1:0]      aluop;
   } ctrl_t;

   // Control word presented while idle.
   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c   = '0;
      c.w = 1'b1;
      return c;
   endfunction

   // Sign-extends the low byte of an instruction word.
   function automatic logic [DW_C-1:0] sext_imm8(input logic [DW_C-1:0] ir);
      return {{(DW_C-IMM_MSB-1){ir[IMM_MSB]}}, ir[IMM_MSB:0]};
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits the IR into register/shift
// fields and classifies it into exactly one instruction class.
module instr_decoder
   import cpu_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned RW = 3
) (
   input  logic [DW-1:0] ir_i,
   output logic [RW-1:0] rn_o,
   output logic [RW-1:0] rd_o,
   output logic [RW-1:0] rm_o,
   output logic [1:0]    sh_o,
   output logic [1:0]    op_o,
   output logic [DW-1:0] imm_o,
   output logic          is_movi_o,
   output logic          is_movr_o,
   output logic          is_alu2_o,
   output logic          is_cmp_o,
   output logic          is_mvn_o,
   output logic          illegal_o
);

   logic [2:0] opcode;

   assign opcode = ir_i[OPC_MSB:OPC_LSB];
   assign op_o   = ir_i[OP_MSB:OP_LSB];
   assign rn_o   = ir_i[RN_MSB:RN_LSB];
   assign rd_o   = ir_i[RD_MSB:RD_LSB];
   assign sh_o   = ir_i[SH_MSB:SH_LSB];
   assign rm_o   = ir_i[RM_MSB:RM_LSB];
   assign imm_o  = sext_imm8(ir_i);

   // Classify the instruction; anything not matched is illegal.
   always_comb begin
      is_movi_o = 1'b0;
      is_movr_o = 1'b0;
      is_alu2_o = 1'b0;
      is_cmp_o  = 1'b0;
      is_mvn_o  = 1'b0;
      illegal_o = 1'b0;
      if (opcode == OPC_MOV && op_o == OP_MOV_IMM) begin
         is_movi_o = 1'b1;
      end else if (opcode == OPC_MOV && op_o == OP_MOV_REG) begin
         is_movr_o = 1'b1;
      end else if (opcode == OPC_ALU) begin
         unique case (op_o)
            ALU_ADD, ALU_AND: is_alu2_o = 1'b1;
            ALU_SUB:          is_cmp_o  = 1'b1;
            default:          is_mvn_o  = 1'b1;
         endcase
      end else begin
         illegal_o = 1'b1;
      end
   end

endmodule

// File: rtl/instr_controller.sv
// Instruction register plus sequencing FSM that drives the datapath control
// inputs, executing one instruction per start pulse.
module instr_controller
   import cpu_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned RW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] in,
   input  logic          load,
   input  logic          s,
   output logic          w,
   output logic [RW-1:0] readnum,
   output logic [RW-1:0] writenum,
   output logic          write,
   output logic          vsel,
   output logic          loada,
   output logic          loadb,
   output logic          loadc,
   output logic          loads,
   output logic          asel,
   output logic          bsel,
   output logic [1:0]    shift,
   output logic [1:0]    ALUop,
   output logic [DW-1:0] datapath_in
);

   logic [DW-1:0] ir_q;
   state_e        state_q, state_d;
   ctrl_t         ctrl_q, ctrl_d;

   logic [RW-1:0] rn, rd, rm;
   logic [1:0]    sh, op;
   logic [DW-1:0] imm;
   logic          is_movi, is_movr, is_alu2, is_cmp, is_mvn, illegal;

   instr_decoder #(
      .DW (DW),
      .RW (RW)
   ) u_dec (
      .ir_i      (ir_q),
      .rn_o      (rn),
      .rd_o      (rd),
      .rm_o      (rm),
      .sh_o      (sh),
      .op_o      (op),
      .imm_o     (imm),
      .is_movi_o (is_movi),
      .is_movr_o (is_movr),
      .is_alu2_o (is_alu2),
      .is_cmp_o  (is_cmp),
      .is_mvn_o  (is_mvn),
      .illegal_o (illegal)
   );

   // IR captures a new instruction only while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q <= '0;
      end else if (load && state_q == S_WAIT) begin
         ir_q <= in;
      end
   end

   // Next-state selection from the current state and instruction class.
   always_comb begin
      state_d = S_WAIT;
      unique case (state_q)
         S_WAIT:      state_d = s ? S_DECODE : S_WAIT;
         S_DECODE: begin
            if (is_movi)                 state_d = S_WRITE_IMM;
            else if (is_movr || is_mvn)  state_d = S_GET_B;
            else if (is_alu2 || is_cmp)  state_d = S_GET_A;
            else                         state_d = S_WAIT;
         end
         S_GET_A:     state_d = S_GET_B;
         S_GET_B:     state_d = S_ALU;
         S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
         S_WRITE_REG: state_d = S_WAIT;
         S_WRITE_IMM: state_d = S_WAIT;
         default:     state_d = S_WAIT;
      endcase
   end

   // Control word for the state being entered. Outputs are registered, so
   // they are decoded from state_d; the IR is stable for every state that
   // uses its fields (only the all-zero DECODE word can follow an IR load).
   always_comb begin
      ctrl_d = '0;
      unique case (state_d)
         S_WAIT:   ctrl_d.w = 1'b1;
         S_DECODE: ctrl_d = '0;
         S_GET_A: begin
            ctrl_d.readnum = rn;
            ctrl_d.loada   = 1'b1;
         end
         S_GET_B: begin
            ctrl_d.readnum = rm;
            ctrl_d.loadb   = 1'b1;
         end
         S_ALU: begin
            ctrl_d.shift = sh;
            ctrl_d.aluop = is_movr ? ALU_ADD : op;
            ctrl_d.asel  = is_movr | is_mvn;
            ctrl_d.loads = is_cmp;
            ctrl_d.loadc = ~is_cmp;
         end
         S_WRITE_REG: begin
            ctrl_d.writenum = rd;
            ctrl_d.write    = 1'b1;
            ctrl_d.vsel     = 1'b0;
         end
         S_WRITE_IMM: begin
            ctrl_d.writenum = rn;
            ctrl_d.write    = 1'b1;
            ctrl_d.vsel     = 1'b1;
         end
         default: ctrl_d = '0;
      endcase
   end

   // FSM state and registered Moore outputs; reset aborts any instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ctrl_q  <= ctrl_idle();
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign w           = ctrl_q.w;
   assign readnum     = ctrl_q.readnum;
   assign writenum    = ctrl_q.writenum;
   assign write       = ctrl_q.write;
   assign vsel        = ctrl_q.vsel;
   assign loada       = ctrl_q.loada;
   assign loadb       = ctrl_q.loadb;
   assign loadc       = ctrl_q.loadc;
   assign loads       = ctrl_q.loads;
   assign asel        = ctrl_q.asel;
   assign bsel        = 1'b0;
   assign shift       = ctrl_q.shift;
   assign ALUop       = ctrl_q.aluop;
   assign datapath_in = imm;

   // Only legal-class flag not otherwise consumed by the sequencer.
   logic unused_illegal;
   assign unused_illegal = illegal;

endmodule

// File: tb/tb_instr_controller.sv
// Self-checking bench for instr_controller: directed scenarios plus random
// instruction streams compared against a per-cycle expected-control trace.
module tb_instr_controller;

   logic        clk = 1'b0;
   logic        reset, load, s;
   logic [15:0] instr;
   logic        w, write, vsel, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  shift, ALUop;
   logic [15:0] datapath_in;

   int checks = 0;
   int errors = 0;

   logic [34:0] obs;
   logic [34:0] exp_v;
   logic [18:0] trace[$];
   logic [15:0] ir_m;

   localparam logic [18:0] IDLE_V = {1'b1, 18'b0};
   localparam logic [18:0] DEC_V  = 19'b0;

   instr_controller #(.DW(16), .RW(3)) dut (
      .clk(clk), .reset(reset), .in(instr), .load(load), .s(s),
      .w(w), .readnum(readnum), .writenum(writenum), .write(write),
      .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
      .loads(loads), .asel(asel), .bsel(bsel), .shift(shift),
      .ALUop(ALUop), .datapath_in(datapath_in)
   );

   always #5 clk = ~clk;

   assign obs = {w, readnum, writenum, write, vsel, loada, loadb, loadc,
                 loads, asel, bsel, shift, ALUop, datapath_in};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] sx(input logic [15:0] ir);
      return {{8{ir[7]}}, ir[7:0]};
   endfunction

   function automatic logic [18:0] mk(input logic wv, input logic [2:0] rdn,
      input logic [2:0] wrn, input logic wr, input logic vs, input logic la,
      input logic lb, input logic lc, input logic ls, input logic as,
      input logic [1:0] sh, input logic [1:0] alu);
      return {wv, rdn, wrn, wr, vs, la, lb, lc, ls, as, 1'b0, sh, alu};
   endfunction

   // Reference model: one control word per cycle, starting at the cycle
   // after the start edge and ending with the return to idle.
   function automatic void build_trace(input logic [15:0] ir);
      logic [2:0] opc, rn, rd, rm;
      logic [1:0] op, sh;
      opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
      rd  = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
      trace.delete();
      trace.push_back(DEC_V);
      if (opc == 3'b110 && op == 2'b10) begin
         trace.push_back(mk(0, 0, rn, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
      end else if (opc == 3'b110 && op == 2'b00) begin
         trace.push_back(mk(0, rm, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
         trace.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, sh, 2'b00));
         trace.push_back(mk(0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
      end else if (opc == 3'b101) begin
         if (op != 2'b11)
            trace.push_back(mk(0, rn, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
         trace.push_back(mk(0, rm, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
         trace.push_back(mk(0, 0, 0, 0, 0, 0, 0, op != 2'b01, op == 2'b01,
                            op == 2'b11, sh, op));
         if (op != 2'b01)
            trace.push_back(mk(0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
      end
      trace.push_back(IDLE_V);
   endfunction

   // Load an instruction and start it; leaves the bench one cycle after the
   // start edge with load/s released.
   task automatic start_instr(input logic [15:0] ir, input bit same_edge);
      if (same_edge) begin
         load = 1'b1; instr = ir; s = 1'b1;
         tick();
      end else begin
         load = 1'b1; instr = ir; s = 1'b0;
         tick();
         load = 1'b0; instr = 16'($urandom); s = 1'b1;
         tick();
      end
      ir_m = ir;
      load = 1'b0; s = 1'b0;
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 6))
         0: r[15:11] = 5'b11010;
         1: r[15:11] = 5'b11000;
         2: r[15:11] = 5'b10100;
         3: r[15:11] = 5'b10101;
         4: r[15:11] = 5'b10110;
         5: r[15:11] = 5'b10111;
         default: ;
      endcase
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b1; load = 1'b0; s = 1'b0; instr = 16'h0;
      tick();
      checks++;
      if (obs !== {IDLE_V, 16'h0000}) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", obs, {IDLE_V, 16'h0000});
      end
      reset = 1'b0;
      tick();
      checks++;
      if (w !== 1'b1 || write !== 1'b0 || loada !== 1'b0 || loadb !== 1'b0 ||
          loadc !== 1'b0 || loads !== 1'b0 || datapath_in !== 16'h0000) begin
         errors++;
         $display("FAIL reset_idle: got %h expected w=1 others 0", obs);
      end
      ir_m = 16'h0;
   endtask

   task automatic test_mov_imm();
      int lat;
      start_instr(16'hD1FE, 1'b0);
      build_trace(ir_m);
      lat = -1;
      for (int i = 0; i < trace.size(); i++) begin
         if (i > 0) tick();
         exp_v = {trace[i], sx(ir_m)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL mov_imm step %0d: got %h expected %h", i, obs, exp_v);
         end
         if (i == 1) begin
            checks++;
            if (writenum !== 3'd1 || write !== 1'b1 || vsel !== 1'b1 ||
                datapath_in !== 16'hFFFE) begin
               errors++;
               $display("FAIL mov_imm_write: got wn=%0d wr=%b vsel=%b dp=%h expected 1 1 1 fffe",
                        writenum, write, vsel, datapath_in);
            end
         end
         if (w === 1'b1 && lat < 0) lat = i;
      end
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL mov_imm_latency: got %0d expected 2", lat);
      end
   endtask

   task automatic test_add();
      int lat;
      start_instr(16'hA148, 1'b0);
      build_trace(ir_m);
      lat = -1;
      for (int i = 0; i < trace.size(); i++) begin
         if (i > 0) tick();
         exp_v = {trace[i], sx(ir_m)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL add step %0d: got %h expected %h", i, obs, exp_v);
         end
         if (i == 3) begin
            checks++;
            if (shift !== 2'b01 || ALUop !== 2'b00 || asel !== 1'b0 || loadc !== 1'b1) begin
               errors++;
               $display("FAIL add_alu: got sh=%b op=%b asel=%b lc=%b expected 01 00 0 1",
                        shift, ALUop, asel, loadc);
            end
         end
         if (w === 1'b1 && lat < 0) lat = i;
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL add_latency: got %0d expected 5", lat);
      end
   endtask

   task automatic test_cmp();
      int lat;
      bit wrote;
      start_instr(16'hA801, 1'b1);
      build_trace(ir_m);
      lat = -1; wrote = 0;
      for (int i = 0; i < trace.size(); i++) begin
         if (i > 0) tick();
         exp_v = {trace[i], sx(ir_m)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL cmp step %0d: got %h expected %h", i, obs, exp_v);
         end
         if (i == 3) begin
            checks++;
            if (loads !== 1'b1 || loadc !== 1'b0) begin
               errors++;
               $display("FAIL cmp_alu: got loads=%b loadc=%b expected 1 0", loads, loadc);
            end
         end
         if (write === 1'b1) wrote = 1;
         if (w === 1'b1 && lat < 0) lat = i;
      end
      checks++;
      if (lat !== 4 || wrote) begin
         errors++;
         $display("FAIL cmp_latency: got lat=%0d wrote=%0d expected 4 0", lat, wrote);
      end
   endtask

   task automatic test_mvn();
      int lat;
      start_instr(16'hB881, 1'b0);
      build_trace(ir_m);
      lat = -1;
      for (int i = 0; i < trace.size(); i++) begin
         if (i > 0) tick();
         exp_v = {trace[i], sx(ir_m)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL mvn step %0d: got %h expected %h", i, obs, exp_v);
         end
         if (i == 2) begin
            checks++;
            if (asel !== 1'b1 || ALUop !== 2'b11) begin
               errors++;
               $display("FAIL mvn_alu: got asel=%b op=%b expected 1 11", asel, ALUop);
            end
         end
         if (i == 3) begin
            checks++;
            if (writenum !== 3'd4 || write !== 1'b1) begin
               errors++;
               $display("FAIL mvn_write: got wn=%0d wr=%b expected 4 1", writenum, write);
            end
         end
         if (w === 1'b1 && lat < 0) lat = i;
      end
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL mvn_latency: got %0d expected 4", lat);
      end
   endtask

   task automatic test_illegal();
      int lat;
      bit wrote;
      start_instr(16'hE000, 1'b0);
      build_trace(ir_m);
      lat = -1; wrote = 0;
      for (int i = 0; i < trace.size(); i++) begin
         if (i > 0) tick();
         exp_v = {trace[i], sx(ir_m)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL illegal step %0d: got %h expected %h", i, obs, exp_v);
         end
         if (write === 1'b1) wrote = 1;
         if (w === 1'b1 && lat < 0) lat = i;
      end
      checks++;
      if (lat !== 1 || wrote) begin
         errors++;
         $display("FAIL illegal_latency: got lat=%0d wrote=%0d expected 1 0", lat, wrote);
      end
   endtask

   task automatic test_ignored_load();
      start_instr(16'hA148, 1'b1);
      build_trace(ir_m);
      for (int i = 0; i < trace.size(); i++) begin
         if (i > 0) tick();
         exp_v = {trace[i], sx(ir_m)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL ignored_load step %0d: got %h expected %h", i, obs, exp_v);
         end
         if (i == 2) begin
            load = 1'b1; instr = 16'hD007; s = 1'b1;
         end else begin
            load = 1'b0; s = 1'b0;
         end
      end
      checks++;
      if (datapath_in !== 16'h0048) begin
         errors++;
         $display("FAIL ignored_load_ir: got %h expected 0048", datapath_in);
      end
   endtask

   task automatic test_reset_mid_op();
      bit wrote;
      start_instr(16'hA148, 1'b0);
      build_trace(ir_m);
      wrote = 0;
      for (int i = 0; i <= 3; i++) begin
         if (i > 0) tick();
         if (write === 1'b1) wrote = 1;
         exp_v = {trace[i], sx(ir_m)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid step %0d: got %h expected %h", i, obs, exp_v);
         end
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ir_m = 16'h0;
      for (int i = 0; i < 3; i++) begin
         if (write === 1'b1) wrote = 1;
         checks++;
         if (obs !== {IDLE_V, 16'h0000}) begin
            errors++;
            $display("FAIL reset_mid_idle %0d: got %h expected %h", i, obs, {IDLE_V, 16'h0000});
         end
         tick();
      end
      checks++;
      if (wrote) begin
         errors++;
         $display("FAIL reset_mid_nowrite: got write seen expected none");
      end
      // Cleared IR decodes as illegal: one DECODE cycle then idle.
      s = 1'b1;
      tick();
      s = 1'b0;
      checks++;
      if (obs !== {DEC_V, 16'h0000}) begin
         errors++;
         $display("FAIL reset_mid_ir0: got %h expected %h", obs, {DEC_V, 16'h0000});
      end
      tick();
      checks++;
      if (obs !== {IDLE_V, 16'h0000}) begin
         errors++;
         $display("FAIL reset_mid_ir0_idle: got %h expected %h", obs, {IDLE_V, 16'h0000});
      end
   endtask

   task automatic test_reset_priority();
      reset = 1'b1; load = 1'b1; instr = 16'hD1FE; s = 1'b1;
      tick();
      reset = 1'b0; load = 1'b0; s = 1'b0;
      ir_m = 16'h0;
      checks++;
      if (obs !== {IDLE_V, 16'h0000}) begin
         errors++;
         $display("FAIL reset_priority: got %h expected %h", obs, {IDLE_V, 16'h0000});
      end
      tick();
      checks++;
      if (obs !== {IDLE_V, 16'h0000}) begin
         errors++;
         $display("FAIL reset_priority_hold: got %h expected %h", obs, {IDLE_V, 16'h0000});
      end
   endtask

   task automatic test_random_back_to_back();
      for (int n = 0; n < 60; n++) begin
         start_instr(rand_instr(), bit'($urandom_range(0, 1)));
         build_trace(ir_m);
         for (int i = 0; i < trace.size(); i++) begin
            if (i > 0) tick();
            exp_v = {trace[i], sx(ir_m)};
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL random ir=%h step %0d: got %h expected %h", ir_m, i, obs, exp_v);
            end
            if (i < trace.size() - 1) begin
               load  = 1'($urandom_range(0, 1));
               s     = 1'($urandom_range(0, 1));
               instr = 16'($urandom);
            end else begin
               load = 1'b0; s = 1'b0;
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; s = 1'b0; instr = 16'h0; ir_m = 16'h0;
      test_reset();
      test_mov_imm();
      test_add();
      test_cmp();
      test_mvn();
      test_illegal();
      test_ignored_load();
      test_reset_mid_op();
      test_reset_priority();
      test_random_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
